// File: rtl/grant_mux_pkg.sv
// Shared types and defaults for the grant mux stage and its arbiter.
// The lock-state enum is only used when GRANT_MUX_PKT_LOCK_EN is defined.
package grant_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    localparam int DEFAULT_SIZE = 4;
    localparam int DEFAULT_DW   = 8;

endpackage

// File: rtl/grant_mux_stage_fixed_prio_gnt.sv
// Combinational fixed-priority arbiter: one-hot grant to the highest-index request.
module fixed_prio_gnt
    import grant_mux_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE
) (
    input  logic [SIZE-1:0] i_req,
    output logic [SIZE-1:0] o_gnt
);

    // Scanning upward lets each later (higher-index) request override earlier ones.
    always_comb begin
        o_gnt = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (i_req[i]) begin
                o_gnt    = '0;
                o_gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grant_mux_stage.sv
// N-to-1 beat mux with MSB-first arbitration and a one-entry output register.
// Define GRANT_MUX_PKT_LOCK_EN to hold the grant on one channel until its last beat.
module grant_mux_stage
    import grant_mux_pkg::*;
#(
    parameter int SIZE = DEFAULT_SIZE,
    parameter int DW   = DEFAULT_DW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SIZE-1:0]          in_valid,
    input  logic [SIZE*DW-1:0]       in_data,
    input  logic [SIZE-1:0]          in_last,
    output logic [SIZE-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DW-1:0]            out_data,
    output logic                     out_last,
    output logic [$clog2(SIZE)-1:0]  out_src,
    input  logic                     out_ready
);

    localparam int IW = $clog2(SIZE);

    logic [SIZE-1:0] w_prioGnt;
    logic [SIZE-1:0] w_gnt;
    logic            w_canLoad;
    logic            w_xfer;
    logic [IW-1:0]   w_selIdx;
    logic [DW-1:0]   w_selData;
    logic            w_selLast;

    logic            r_outValid;
    logic [DW-1:0]   r_outData;
    logic            r_outLast;
    logic [IW-1:0]   r_outSrc;

    fixed_prio_gnt #(.SIZE(SIZE)) u_prio (
        .i_req (in_valid),
        .o_gnt (w_prioGnt)
    );

`ifdef GRANT_MUX_PKT_LOCK_EN
    lock_state_e     r_state;
    lock_state_e     w_nextState;
    logic [IW-1:0]   r_lockIdx;
    logic [SIZE-1:0] w_lockGnt;

    // While locked only the owning channel may be granted, and only when it is valid.
    always_comb begin
        w_lockGnt = '0;
        for (int i = 0; i < SIZE; i++) begin
            w_lockGnt[i] = in_valid[i] && (r_lockIdx == IW'(i));
        end
    end

    assign w_gnt = (r_state == LOCKED) ? w_lockGnt : w_prioGnt;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_xfer && !w_selLast) w_nextState = LOCKED;
            LOCKED:  if (w_xfer && w_selLast)  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_lockIdx <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && w_xfer && !w_selLast) begin
                r_lockIdx <= w_selIdx;
            end
        end
    end
`else
    assign w_gnt = w_prioGnt;
`endif

    // Reset gates in_ready directly since the empty register would otherwise allow a grant.
    assign w_canLoad = ~r_outValid | out_ready;
    assign in_ready  = w_gnt & {SIZE{w_canLoad & rst_n}};
    assign w_xfer    = |(in_valid & in_ready);

    always_comb begin
        w_selIdx = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (w_gnt[i]) w_selIdx = IW'(i);
        end
    end

    assign w_selData = in_data[w_selIdx*DW +: DW];
    assign w_selLast = in_last[w_selIdx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outLast  <= 1'b0;
            r_outSrc   <= '0;
        end else if (w_xfer) begin
            r_outValid <= 1'b1;
            r_outData  <= w_selData;
            r_outLast  <= w_selLast;
            r_outSrc   <= w_selIdx;
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_last  = r_outLast;
    assign out_src   = r_outSrc;

endmodule

// File: tb/tb_grant_mux_stage.sv
// Scoreboard bench for grant_mux_stage; expectations follow GRANT_MUX_PKT_LOCK_EN.
module tb_grant_mux_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_src;
    logic        out_ready;

    int passCount  = 0;
    int checkCount = 0;
    logic [10:0] sb[$];

    grant_mux_stage #(.SIZE(4), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] mkData(input logic [3:0] seq);
        return {4'd3, seq, 4'd2, seq, 4'd1, seq, 4'd0, seq};
    endfunction

    // One cycle of stimulus: drive at negedge, check in_ready, queue the beat expected to transfer.
    task automatic applyStimulus(input string name, input logic [3:0] v, input logic [3:0] l,
                                 input logic [31:0] d, input logic ordy, input logic [3:0] expRdy);
        int idx;
        @(negedge clk);
        in_valid  = v;
        in_last   = l;
        in_data   = d;
        out_ready = ordy;
        #1;
        checkOutput({name, " in_ready"}, 32'(in_ready), 32'(expRdy));
        if (expRdy != 4'b0000) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (expRdy[i]) idx = i;
            sb.push_back({2'(idx), d[idx*8 +: 8], l[idx]});
        end
    endtask

    // Monitor: pops and compares whenever a beat is handed downstream.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected beat", {21'd0, out_src, out_data, out_last}, 32'h7ff);
                end else begin
                    checkOutput("beat", {21'd0, out_src, out_data, out_last}, {21'd0, sb.pop_front()});
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        in_data   = mkData(4'h0);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("reset in_ready", 32'(in_ready), 32'h0);
        checkOutput("reset out_valid", 32'(out_valid), 32'h0);
        checkOutput("reset out_data", 32'(out_data), 32'h0);
        checkOutput("reset out_src", 32'(out_src), 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 4'b0000;

        // Priority between two single-beat requesters.
        applyStimulus("prio c1", 4'b0101, 4'b1111, mkData(4'h1), 1'b1, 4'b0100);
        applyStimulus("prio c2", 4'b0001, 4'b1111, mkData(4'h2), 1'b1, 4'b0001);
        applyStimulus("prio c3", 4'b0000, 4'b1111, mkData(4'h3), 1'b1, 4'b0000);

        // Three-beat packet on ch1 with ch3 competing from beat 2.
        applyStimulus("pkt c1", 4'b0010, 4'b0000, mkData(4'h4), 1'b1, 4'b0010);
`ifdef GRANT_MUX_PKT_LOCK_EN
        applyStimulus("pkt c2", 4'b1010, 4'b0000, mkData(4'h5), 1'b1, 4'b0010);
        applyStimulus("pkt c3", 4'b1010, 4'b0010, mkData(4'h6), 1'b1, 4'b0010);
`else
        applyStimulus("pkt c2", 4'b1010, 4'b0000, mkData(4'h5), 1'b1, 4'b1000);
        applyStimulus("pkt c3", 4'b1010, 4'b0010, mkData(4'h6), 1'b1, 4'b1000);
`endif
        applyStimulus("pkt c4", 4'b1010, 4'b1010, mkData(4'h7), 1'b1, 4'b1000);
        applyStimulus("pkt c5", 4'b0010, 4'b0010, mkData(4'h8), 1'b1, 4'b0010);
        applyStimulus("pkt c6", 4'b0000, 4'b0000, mkData(4'h9), 1'b1, 4'b0000);

        // Downstream stall: the A5 beat must hold and nothing new may be accepted.
        applyStimulus("stall c1", 4'b0010, 4'b0010, 32'h0000_A500, 1'b1, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            applyStimulus("stall hold", 4'b0010, 4'b0010, 32'h0000_5A00, 1'b0, 4'b0000);
            checkOutput("stall out_data", 32'(out_data), 32'h0000_00A5);
            checkOutput("stall out_valid", 32'(out_valid), 32'h1);
        end
        applyStimulus("stall c5", 4'b0010, 4'b0010, 32'h0000_5A00, 1'b1, 4'b0010);
        applyStimulus("stall c6", 4'b0000, 4'b0000, mkData(4'hA), 1'b1, 4'b0000);

        // Reset in the middle of a ch2 packet discards the lock and the held beat.
        applyStimulus("rst c1", 4'b0100, 4'b0000, mkData(4'hB), 1'b0, 4'b0100);
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        #1;
        checkOutput("midrst in_ready", 32'(in_ready), 32'h0);
        checkOutput("midrst out_valid", 32'(out_valid), 32'h0);
        sb.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 4'b0000;
        applyStimulus("rst c2", 4'b1100, 4'b1100, mkData(4'hC), 1'b1, 4'b1000);
        applyStimulus("rst c3", 4'b0000, 4'b0000, mkData(4'hD), 1'b1, 4'b0000);

        // Locked ch0 drops valid for two cycles while ch3 is waiting.
        applyStimulus("drop c1", 4'b0001, 4'b0000, mkData(4'h1), 1'b1, 4'b0001);
`ifdef GRANT_MUX_PKT_LOCK_EN
        applyStimulus("drop c2", 4'b1000, 4'b1000, mkData(4'h2), 1'b1, 4'b0000);
        checkOutput("drop out_valid", 32'(out_valid), 32'h0);
        applyStimulus("drop c3", 4'b1000, 4'b1000, mkData(4'h3), 1'b1, 4'b0000);
        checkOutput("drop out_valid", 32'(out_valid), 32'h0);
        applyStimulus("drop c4", 4'b1001, 4'b1001, mkData(4'h4), 1'b1, 4'b0001);
`else
        applyStimulus("drop c2", 4'b1000, 4'b1000, mkData(4'h2), 1'b1, 4'b1000);
        applyStimulus("drop c3", 4'b1000, 4'b1000, mkData(4'h3), 1'b1, 4'b1000);
        applyStimulus("drop c4", 4'b1001, 4'b1001, mkData(4'h4), 1'b1, 4'b1000);
`endif
        applyStimulus("drop c5", 4'b1000, 4'b1000, mkData(4'h5), 1'b1, 4'b1000);
        applyStimulus("drop c6", 4'b0000, 4'b0000, mkData(4'h6), 1'b1, 4'b0000);

        @(negedge clk);
        #3;
        checkOutput("scoreboard empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
